// File: rtl/scene_restoration_pipe.sv
// scene_restoration_pipe: three-stage valid/ready pipeline computing
// J = A + (I - A) * (1/t) per channel, with round-half-up and clamping to
// the pixel range. Optional previous-frame saturation counter enabled by
// defining SR_SAT_COUNT_EN; without it o_sat_cnt is tied to zero.
// Handshake: a beat moves across an interface on a clock edge where valid
// and ready are both high; valid never depends on ready, ready may depend
// combinationally on the downstream ready.
module scene_restoration_pipe #(
   parameter int PIX_W     = 8,
   parameter int NCH       = 3,
   parameter int RECIP_W   = 11,
   parameter int FRAC_BITS = 3,
   parameter int CNT_W     = 20
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [NCH*PIX_W-1:0]   i_pix,
   input  logic [NCH*PIX_W-1:0]   i_atm,
   input  logic [RECIP_W-1:0]     i_recip_t,
   input  logic                   i_sof,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [NCH*PIX_W-1:0]   o_pix,
   output logic                   o_sof,
   output logic [NCH-1:0]         o_sat,
   output logic [CNT_W-1:0]       o_sat_cnt
);
   localparam int PW      = PIX_W + RECIP_W;
   localparam int SW      = PW + 1;
   localparam int HALF_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
   localparam logic [SW-1:0]    HALF    = (FRAC_BITS > 0) ? (SW'(1) << HALF_SH) : '0;
   localparam logic [PIX_W-1:0] PIX_MAX = '1;

   logic                   r_v1, r_v2, r_v3;
   logic                   w_ld1, w_ld2, w_ld3;

   logic [NCH*PIX_W-1:0]   r1_atm;
   logic [RECIP_W-1:0]     r1_recip;
   logic [NCH-1:0]         r1_sign;
   logic [PIX_W-1:0]       r1_mag [NCH];
   logic                   r1_sof;
   logic [NCH-1:0]         w1_sign;
   logic [PIX_W-1:0]       w1_mag [NCH];

   logic [NCH*PIX_W-1:0]   r2_atm;
   logic [NCH-1:0]         r2_sign;
   logic [SW-1:0]          r2_scaled [NCH];
   logic                   r2_sof;
   logic [PW-1:0]          w2_prod [NCH];
   logic [SW-1:0]          w2_scaled [NCH];

   logic [NCH*PIX_W-1:0]   r3_pix;
   logic [NCH-1:0]         r3_sat;
   logic                   r3_sof;
   logic [SW:0]            w3_sum [NCH];
   logic [NCH*PIX_W-1:0]   w3_pix;
   logic [NCH-1:0]         w3_sat;

   // Load chain: a stage accepts when empty or when its successor accepts.
   always_comb begin
      w_ld3 = !r_v3 || i_ready;
      w_ld2 = !r_v2 || w_ld3;
      w_ld1 = !r_v1 || w_ld2;
   end

   assign o_ready = w_ld1;
   assign o_valid = r_v3;
   assign o_pix   = r3_pix;
   assign o_sof   = r3_sof;
   assign o_sat   = r3_sat;

   // Stage valid bits; a loading stage takes its predecessor's valid, so bubbles collapse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else begin
         if (w_ld1) r_v1 <= i_valid;
         if (w_ld2) r_v2 <= r_v1;
         if (w_ld3) r_v3 <= r_v2;
      end
   end

   // S1 combinational: sign and magnitude of I - A, subtracting in the order that cannot wrap.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         w1_sign[c] = i_pix[c*PIX_W +: PIX_W] < i_atm[c*PIX_W +: PIX_W];
         w1_mag[c]  = w1_sign[c] ? (i_atm[c*PIX_W +: PIX_W] - i_pix[c*PIX_W +: PIX_W])
                                 : (i_pix[c*PIX_W +: PIX_W] - i_atm[c*PIX_W +: PIX_W]);
      end
   end

   // S1 data registers, captured only for real beats.
   always_ff @(posedge i_clk) begin
      if (w_ld1 && i_valid) begin
         r1_atm   <= i_atm;
         r1_recip <= i_recip_t;
         r1_sign  <= w1_sign;
         r1_sof   <= i_sof;
         for (int c = 0; c < NCH; c++) r1_mag[c] <= w1_mag[c];
      end
   end

   // S2 combinational: exact product then round-half-up drop of the fraction bits.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         w2_prod[c]   = PW'(r1_mag[c]) * PW'(r1_recip);
         w2_scaled[c] = (SW'(w2_prod[c]) + HALF) >> FRAC_BITS;
      end
   end

   // S2 data registers.
   always_ff @(posedge i_clk) begin
      if (w_ld2 && r_v1) begin
         r2_atm  <= r1_atm;
         r2_sign <= r1_sign;
         r2_sof  <= r1_sof;
         for (int c = 0; c < NCH; c++) r2_scaled[c] <= w2_scaled[c];
      end
   end

   // S3 combinational: add or subtract the scaled delta, clamp, flag only real clamps.
   always_comb begin
      w3_pix = '0;
      w3_sat = '0;
      for (int c = 0; c < NCH; c++) begin
         w3_sum[c] = (SW+1)'(r2_atm[c*PIX_W +: PIX_W]) + (SW+1)'(r2_scaled[c]);
         if (!r2_sign[c]) begin
            if (w3_sum[c] > (SW+1)'(PIX_MAX)) begin
               w3_pix[c*PIX_W +: PIX_W] = PIX_MAX;
               w3_sat[c]                = 1'b1;
            end else begin
               w3_pix[c*PIX_W +: PIX_W] = w3_sum[c][PIX_W-1:0];
            end
         end else if (r2_scaled[c] >= SW'(r2_atm[c*PIX_W +: PIX_W])) begin
            // Exactly reaching zero is not a clamp.
            w3_pix[c*PIX_W +: PIX_W] = '0;
            w3_sat[c]                = r2_scaled[c] != SW'(r2_atm[c*PIX_W +: PIX_W]);
         end else begin
            w3_pix[c*PIX_W +: PIX_W] = r2_atm[c*PIX_W +: PIX_W] - r2_scaled[c][PIX_W-1:0];
         end
      end
   end

   // S3 output registers; reset because they drive ports directly.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r3_pix <= '0;
         r3_sat <= '0;
         r3_sof <= 1'b0;
      end else if (w_ld3 && r_v2) begin
         r3_pix <= w3_pix;
         r3_sat <= w3_sat;
         r3_sof <= r2_sof;
      end
   end

`ifdef SR_SAT_COUNT_EN
   logic [CNT_W-1:0] r_acc;
   logic [CNT_W-1:0] r_sat_cnt;
   logic [CNT_W-1:0] w_pop;
   logic [CNT_W:0]   w_acc_sum;
   logic [CNT_W-1:0] w_acc_nxt;

   // Popcount of the outgoing flags and saturating accumulation.
   always_comb begin
      w_pop = '0;
      for (int c = 0; c < NCH; c++) w_pop = w_pop + CNT_W'(r3_sat[c]);
      w_acc_sum = {1'b0, r_acc} + {1'b0, w_pop};
      w_acc_nxt = w_acc_sum[CNT_W] ? '1 : w_acc_sum[CNT_W-1:0];
   end

   // On a sof transfer publish the finished frame's count and restart with this beat.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc     <= '0;
         r_sat_cnt <= '0;
      end else if (r_v3 && i_ready) begin
         if (r3_sof) begin
            r_sat_cnt <= r_acc;
            r_acc     <= w_pop;
         end else begin
            r_acc     <= w_acc_nxt;
         end
      end
   end

   assign o_sat_cnt = r_sat_cnt;
`else
   assign o_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_scene_restoration_pipe.sv
// Bench for scene_restoration_pipe with default parameters (3 x 8-bit
// channels, 11-bit 1/t with 3 fraction bits). Build with SR_SAT_COUNT_EN
// defined to also exercise the previous-frame saturation counter.
module tb_scene_restoration_pipe;
   localparam int PW    = 8;
   localparam int NC    = 3;
   localparam int RW    = 11;
   localparam int FRAC  = 3;
   localparam int CW    = 20;
   localparam int HALFV = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_valid = 1'b0;
   logic              o_ready;
   logic [NC*PW-1:0]  i_pix = '0;
   logic [NC*PW-1:0]  i_atm = '0;
   logic [RW-1:0]     i_recip_t = '0;
   logic              i_sof = 1'b0;
   logic              o_valid;
   logic              i_ready = 1'b1;
   logic [NC*PW-1:0]  o_pix;
   logic              o_sof;
   logic [NC-1:0]     o_sat;
   logic [CW-1:0]     o_sat_cnt;

   // expected entry: {sof, sat[2:0], pix[23:0]}
   logic [27:0]       exp_q[$];
   int                n_chk = 0;
   int                n_pass = 0;
   logic              rnd_rdy = 1'b0;
   logic              saw_drop = 1'b0;
   logic              held = 1'b0;
   logic [27:0]       h_val;

   scene_restoration_pipe #(
      .PIX_W(PW), .NCH(NC), .RECIP_W(RW), .FRAC_BITS(FRAC), .CNT_W(CW)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_pix(i_pix), .i_atm(i_atm), .i_recip_t(i_recip_t), .i_sof(i_sof),
      .o_valid(o_valid), .i_ready(i_ready), .o_pix(o_pix), .o_sof(o_sof),
      .o_sat(o_sat), .o_sat_cnt(o_sat_cnt)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [23:0] rep(input int v);
      return {3{8'(v)}};
   endfunction

   // Reference model in plain integer arithmetic.
   function automatic logic [27:0] model(input logic [23:0] p, input logic [23:0] a,
                                         input logic [10:0] r, input logic s);
      logic [23:0] j;
      logic [2:0]  st;
      int iv, av, m, sc, jj;
      j  = '0;
      st = '0;
      for (int c = 0; c < NC; c++) begin
         iv = int'(p[c*8 +: 8]);
         av = int'(a[c*8 +: 8]);
         m  = (iv >= av) ? iv - av : av - iv;
         sc = (m * int'(r) + HALFV) >> FRAC;
         if (iv >= av) begin
            jj = av + sc;
            if (jj > 255) begin jj = 255; st[c] = 1'b1; end
         end else if (sc > av) begin
            jj = 0; st[c] = 1'b1;
         end else begin
            jj = av - sc;
         end
         j[c*8 +: 8] = 8'(jj);
      end
      return {s, st, j};
   endfunction

   // driver: present a beat, push its expectation when it is accepted
   task automatic send(input logic [23:0] p, input logic [23:0] a, input logic [10:0] r,
                       input logic s, input logic [27:0] e);
      bit ok;
      ok = 1'b0;
      i_pix = p; i_atm = a; i_recip_t = r; i_sof = s; i_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (o_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("send_timeout", 32'(o_ready), 32'd1);
      else exp_q.push_back(e);
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic send_rand(input logic s);
      logic [23:0] p, a;
      logic [10:0] r;
      p = 24'($urandom); a = 24'($urandom);
      r = 11'($urandom_range(0, 40));
      send(p, a, r, s, model(p, a, r, s));
   endtask

   task automatic wait_drain();
      int k;
      for (k = 0; k < 500 && exp_q.size() != 0; k++) @(posedge clk);
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      #1;
   endtask

   // random downstream ready
   always @(posedge clk) begin
      if (rnd_rdy) begin #1; i_ready = 1'($urandom_range(0, 1)); end
   end

   // scoreboard / monitor, sampled mid-cycle
   always @(negedge clk) begin
      logic [27:0] e;
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (i_valid && !o_ready) saw_drop = 1'b1;
         if (held) begin
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_beat", 32'({o_sof, o_sat, o_pix}), 32'(h_val));
         end
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) chk("stray_beat", 32'(o_valid), 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("pix", 32'(o_pix), 32'(e[23:0]));
               chk("sat", 32'(o_sat), 32'(e[26:24]));
               chk("sof", 32'(o_sof), 32'(e[27]));
            end
         end
         held  = o_valid && !i_ready;
         h_val = {o_sof, o_sat, o_pix};
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int exp_cnt1;
      // reset state
      #12;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_pix", 32'(o_pix), 32'd0);
      chk("rst_sat", 32'(o_sat), 32'd0);
      chk("rst_sof", 32'(o_sof), 32'd0);
      chk("rst_cnt", 32'(o_sat_cnt), 32'd0);
      @(posedge clk); #3; rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", 32'(o_ready), 32'd1);

      // latency: 3 edges from acceptance to o_valid
      send(rep(120), rep(100), 11'd16, 1'b1, {1'b1, 3'b000, rep(140)});
      chk("lat_1", 32'(o_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_2", 32'(o_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_3", 32'(o_valid), 32'd1);
      wait_drain();

      // directed vectors, back to back
      send(rep(200), rep(100), 11'd16, 1'b0, {1'b0, 3'b111, rep(255)});
      send(rep(90),  rep(100), 11'd16, 1'b0, {1'b0, 3'b000, rep(80)});
      send(rep(40),  rep(100), 11'd16, 1'b0, {1'b0, 3'b111, rep(0)});
      send(rep(101), rep(100), 11'd12, 1'b0, {1'b0, 3'b000, rep(102)});
      send(rep(7),   rep(100), 11'd0,  1'b0, {1'b0, 3'b000, rep(100)});
      send(rep(55),  rep(55),  11'd2047, 1'b0, {1'b0, 3'b000, rep(55)});
      send(rep(50),  rep(100), 11'd16, 1'b0, {1'b0, 3'b000, rep(0)});
      send({8'd10, 8'd0, 8'd255}, {8'd10, 8'd255, 8'd0}, 11'd2047, 1'b0,
           {1'b0, 3'b011, 8'd10, 8'd0, 8'd255});
      wait_drain();

      // 8-beat stream with downstream stalled for 4 cycles
      saw_drop = 1'b0;
      fork
         begin
            for (int b = 0; b < 8; b++) send_rand(1'(b == 0));
         end
         begin
            repeat (3) @(posedge clk);
            #1 i_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 i_ready = 1'b1;
         end
      join
      wait_drain();
      chk("ready_drop", 32'(saw_drop), 32'd1);

      // random traffic with random downstream ready
      rnd_rdy = 1'b1;
      for (int b = 0; b < 40; b++) send_rand(1'($urandom_range(0, 7) == 0));
      wait_drain();
      rnd_rdy = 1'b0;
      @(posedge clk); #1 i_ready = 1'b1;

      // mid-stream asynchronous reset with two beats held
      i_ready = 1'b0;
      send_rand(1'b0);
      send_rand(1'b0);
      repeat (3) @(posedge clk);
      #2;
      chk("pre_rst_valid", 32'(o_valid), 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("async_valid", 32'(o_valid), 32'd0);
      chk("async_pix", 32'(o_pix), 32'd0);
      chk("async_sat", 32'(o_sat), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      i_ready = 1'b1;
      @(posedge clk); #1;
      chk("ready_post_rst", 32'(o_ready), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      chk("no_stale", 32'(o_valid), 32'd0);

      // saturation count: frame with 5 clamps, then sof without clamps
`ifdef SR_SAT_COUNT_EN
      exp_cnt1 = 5;
`else
      exp_cnt1 = 0;
`endif
      send(rep(120), rep(100), 11'd16, 1'b1, {1'b1, 3'b000, rep(140)});
      send(rep(200), rep(100), 11'd16, 1'b0, {1'b0, 3'b111, rep(255)});
      send({8'd120, 8'd40, 8'd200}, rep(100), 11'd16, 1'b0,
           {1'b0, 3'b011, 8'd140, 8'd0, 8'd255});
      send(rep(90), rep(100), 11'd16, 1'b1, {1'b1, 3'b000, rep(80)});
      wait_drain();
      chk("sat_cnt_frame1", 32'(o_sat_cnt), 32'(exp_cnt1));
      send(rep(120), rep(100), 11'd16, 1'b0, {1'b0, 3'b000, rep(140)});
      send(rep(7), rep(100), 11'd0, 1'b1, {1'b1, 3'b000, rep(100)});
      wait_drain();
      chk("sat_cnt_frame2", 32'(o_sat_cnt), 32'd0);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/scene_restoration_pipe.md
Name: scene_restoration_pipe

Overview:
- Parametrised, fully pipelined successor to the single-cycle scene restoration stage of the dehazer.
- Computes J = A + (I - A) * (1/t) per channel for NCH channels, with rounding and clamping to the pixel range.
- Adds valid/ready flow control, start-of-frame propagation and per-channel saturation flags.
- Sits between the transmission-reciprocal / atmospheric-light estimators and the output pixel formatter.

Parameters:
- PIX_W, 8: pixel channel width in bits.
- NCH, 3: number of colour channels, packed channel 0 in the LSBs.
- RECIP_W, 11: width of the unsigned fixed-point 1/t input.
- FRAC_BITS, 3: fractional bits of 1/t. Range 0..RECIP_W-1.
- CNT_W, 20: saturation counter width. Used only with the optional feature.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept an input beat this cycle.
- i_pix  in  NCH*PIX_W  hazy pixel I.
- i_atm  in  NCH*PIX_W  local atmospheric light A.
- i_recip_t  in  RECIP_W  1/t, unsigned, FRAC_BITS fractional bits.
- i_sof  in  1  first pixel of frame; travels with the beat.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the beat.
- o_pix  out  NCH*PIX_W  restored pixel J.
- o_sof  out  1  sof aligned with o_pix.
- o_sat  out  NCH  per-channel flag: clamped to 0 or to max.
- o_sat_cnt  out  CNT_W  saturation count of the previous frame (SR_SAT_COUNT_EN only).

Behaviour:
- Transfers:
  - Input transfer occurs when i_valid && o_ready.
  - Output transfer occurs when o_valid && i_ready.
- Pipeline: 3 registered stages S1..S3, each with its own valid bit.
  - Stage k loads when it is empty or stage k+1 loads that cycle. S3 "loads" when i_ready=1 or S3 is empty.
  - Bubbles collapse.
  - o_ready = !v1 || S2 loads. This is combinational from i_ready through the stage chain.
- Latency: 3 cycles from input transfer to o_valid with i_ready held high. Throughput: 1 beat per cycle.
- S1: register A and 1/t. Compute diff = I - A as a signed PIX_W+1 bit value, per channel. Store sign and |diff|. |diff| is at most 2^PIX_W-1; no wrap.
- S2:
  - prod = |diff| * recip, PIX_W+RECIP_W bits, exact.
  - scaled = (prod + 2^(FRAC_BITS-1)) >> FRAC_BITS, round-half-up. If FRAC_BITS=0, scaled = prod.
- S3, per channel:
  - sign = 0 (I >= A): J = A + scaled, clamped to 2^PIX_W-1. The sum is computed at full width, so it never wraps.
  - sign = 1: J = 0 if scaled >= A, else A - scaled.
  - o_sat[c] = 1 only when a clamp actually changed the value.
- Boundary cases:
  - recip = 0 gives J = A on all channels, with no saturation.
  - I == A gives J = A.
- Stall: while o_valid && !i_ready, o_pix, o_sof and o_sat hold stable and no beat is lost or duplicated. Up to 3 beats are held internally.
- Reset (async assert, synchronous deassert handled upstream):
  - All valid bits go to 0; o_valid=0 immediately.
  - o_pix, o_sof, o_sat = 0; o_sat_cnt = 0.
  - In-flight beats are discarded.
  - o_ready = 1 on the first edge after release.
- Data registers are only required to be reset where they drive outputs.

Optional Feature:
- Macro: SR_SAT_COUNT_EN.
- Defined:
  - An accumulator adds popcount(o_sat) on every output transfer.
  - On an output transfer with o_sof=1, o_sat_cnt latches the accumulator value from before that beat. The accumulator then restarts at popcount(o_sat) of the sof beat.
  - The accumulator saturates at 2^CNT_W-1.
- Undefined: no counter logic; o_sat_cnt is tied to 0.

Test Plan:
- NCH=3, PIX_W=8, FRAC_BITS=3, recip=16 (×2), I=120, A=100, all channels -> J=140 after 3 cycles, o_sat=000.
- Same recip, I=200, A=100 -> 300 clamps to J=255, o_sat=111. I=90, A=100 -> J=80. I=40, A=100 -> J=0, o_sat=111.
- Rounding, recip=12 (1.5): I=101, A=100 -> (12+4)>>3=2 -> J=102. recip=0, I=7, A=100 -> J=100.
- Stream of 8 beats with i_ready low for cycles 3-6 -> o_ready drops once 3 beats are held, outputs are held stable, all 8 beats arrive in order unchanged.
- Assert i_rst_n=0 mid-stream with 2 beats in flight -> o_valid drops asynchronously. After release, o_ready=1 and no stale beats appear.
- SR_SAT_COUNT_EN: frame 1 has 5 channel-clamp events, then a sof beat with no clamps -> o_sat_cnt=5 after that transfer. A following frame with no clamps, then sof -> o_sat_cnt=0.
